// File: rtl/note_tone_pkg.sv
// Shared constants for the note tone bank: octave-0 half-period table,
// note indices and the per-channel state encoding.
package note_tone_pkg;

  localparam int NOTE_MAX = 11;

  localparam int NOTE_C  = 0;
  localparam int NOTE_CS = 1;
  localparam int NOTE_D  = 2;
  localparam int NOTE_DS = 3;
  localparam int NOTE_E  = 4;
  localparam int NOTE_F  = 5;
  localparam int NOTE_FS = 6;
  localparam int NOTE_G  = 7;
  localparam int NOTE_GS = 8;
  localparam int NOTE_A  = 9;
  localparam int NOTE_AS = 10;
  localparam int NOTE_B  = 11;

  // Half-period in 50 MHz cycles for octave 0: round(25e6 / f)
  localparam int unsigned NOTE_TBL_C  = 1528902;
  localparam int unsigned NOTE_TBL_CS = 1443098;
  localparam int unsigned NOTE_TBL_D  = 1362102;
  localparam int unsigned NOTE_TBL_DS = 1285651;
  localparam int unsigned NOTE_TBL_E  = 1213489;
  localparam int unsigned NOTE_TBL_F  = 1145381;
  localparam int unsigned NOTE_TBL_FS = 1081095;
  localparam int unsigned NOTE_TBL_G  = 1020421;
  localparam int unsigned NOTE_TBL_GS = 963154;
  localparam int unsigned NOTE_TBL_A  = 909091;
  localparam int unsigned NOTE_TBL_AS = 858068;
  localparam int unsigned NOTE_TBL_B  = 809910;

  typedef enum logic [1:0] {
    CH_IDLE,
    CH_RUN,
    CH_RUN_PEND
  } ch_state_e;

  function automatic int unsigned note_period(input logic [3:0] note);
    case (int'(note))
      NOTE_C:  return NOTE_TBL_C;
      NOTE_CS: return NOTE_TBL_CS;
      NOTE_D:  return NOTE_TBL_D;
      NOTE_DS: return NOTE_TBL_DS;
      NOTE_E:  return NOTE_TBL_E;
      NOTE_F:  return NOTE_TBL_F;
      NOTE_FS: return NOTE_TBL_FS;
      NOTE_G:  return NOTE_TBL_G;
      NOTE_GS: return NOTE_TBL_GS;
      NOTE_A:  return NOTE_TBL_A;
      NOTE_AS: return NOTE_TBL_AS;
      NOTE_B:  return NOTE_TBL_B;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/note_tone_channel.sv
// One square-wave channel: divider counter plus a queued threshold that is
// swapped in only at a half-period boundary so the output never glitches.
module note_tone_channel
  import note_tone_pkg::*;
#(
  parameter int CNT_W = 21
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [CNT_W-1:0] thr,
  input  logic             gate,
  output logic             tone,
  output logic             tick,
  output logic             pending
);

  ch_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] active_thr;
  logic [CNT_W-1:0] pend_thr;
  logic             boundary;

  assign boundary = (cnt == active_thr - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= CH_IDLE;
      cnt        <= '0;
      active_thr <= CNT_W'(NOTE_TBL_A);
      pend_thr   <= CNT_W'(NOTE_TBL_A);
      tone       <= 1'b0;
      tick       <= 1'b0;
      pending    <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        CH_IDLE: begin
          cnt     <= '0;
          tone    <= 1'b0;
          pending <= 1'b0;
          if (wr) begin
            active_thr <= thr;
            if (gate) state <= CH_RUN;
          end
        end
        default: begin
          if (wr && !gate) begin
            state      <= CH_IDLE;
            cnt        <= '0;
            tone       <= 1'b0;
            pending    <= 1'b0;
            active_thr <= thr;
          end else begin
            // A boundary always closes on the threshold it started with;
            // a write landing on the same edge waits for the next one.
            if (boundary) begin
              cnt  <= '0;
              tone <= ~tone;
              tick <= 1'b1;
              if (state == CH_RUN_PEND) active_thr <= pend_thr;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
            if (wr) begin
              pend_thr <= thr;
              pending  <= 1'b1;
              state    <= CH_RUN_PEND;
            end else if (boundary) begin
              pending <= 1'b0;
              state   <= CH_RUN;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/note_tone_bank.sv
// Multi-channel tone generator: validates and decodes writes, derives the
// octave-shifted threshold and fans it out to the per-channel dividers.
module note_tone_bank
  import note_tone_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int OCT_W   = 3,
  parameter int MAX_OCT = 7,
  parameter int CNT_W   = 21
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] wr_ch,
  input  logic [3:0]                              wr_note,
  input  logic [OCT_W-1:0]                        wr_oct,
  input  logic                                    wr_gate,
  output logic                                    wr_err,
  output logic [N_CH-1:0]                         tone_out,
  output logic [N_CH-1:0]                         edge_tick,
  output logic [N_CH-1:0]                         pending
);

  int unsigned      ch_i;
  int unsigned      oct_i;
  int unsigned      note_i;
  logic             fields_ok;
  logic [CNT_W-1:0] thr;

  // Fields widened so range checks stay meaningful for any port width
  assign ch_i   = 32'(wr_ch);
  assign oct_i  = 32'(wr_oct);
  assign note_i = 32'(wr_note);

  assign fields_ok = (note_i <= unsigned'(NOTE_MAX)) &&
                     (oct_i <= unsigned'(MAX_OCT)) &&
                     (ch_i < unsigned'(N_CH));

  assign thr = CNT_W'(note_period(wr_note)) >> wr_oct;

  always_ff @(posedge clk) begin
    if (rst) wr_err <= 1'b0;
    else     wr_err <= wr_en && !fields_ok;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic ch_wr;
    assign ch_wr = wr_en && fields_ok && (ch_i == unsigned'(i));

    note_tone_channel #(.CNT_W(CNT_W)) u_ch (
      .clk    (clk),
      .rst    (rst),
      .wr     (ch_wr),
      .thr    (thr),
      .gate   (wr_gate),
      .tone   (tone_out[i]),
      .tick   (edge_tick[i]),
      .pending(pending[i])
    );
  end

endmodule

// File: tb/tb_note_tone_bank.sv
// Directed bench for note_tone_bank: a default instance for timing behaviour
// and a 3-channel, 4-bit-octave instance for out-of-range write rejection.
module tb_note_tone_bank;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wr_note = '0;
  logic       wr_gate = 1'b0;

  logic       wr_en_a = 1'b0;
  logic [1:0] wr_ch_a = '0;
  logic [2:0] wr_oct_a = '0;
  logic       wr_err_a;
  logic [3:0] tone_a, edge_a, pend_a;

  logic       wr_en_b = 1'b0;
  logic [1:0] wr_ch_b = '0;
  logic [3:0] wr_oct_b = '0;
  logic       wr_err_b;
  logic [2:0] tone_b, edge_b, pend_b;

  int total = 0;
  int bad = 0;

  localparam int THR_A7 = 7102;
  localparam int THR_B7 = 6327;

  note_tone_bank dut (
    .clk(clk), .rst(rst), .wr_en(wr_en_a), .wr_ch(wr_ch_a), .wr_note(wr_note),
    .wr_oct(wr_oct_a), .wr_gate(wr_gate), .wr_err(wr_err_a),
    .tone_out(tone_a), .edge_tick(edge_a), .pending(pend_a)
  );

  note_tone_bank #(.N_CH(3), .OCT_W(4), .MAX_OCT(7), .CNT_W(21)) dut_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_b), .wr_ch(wr_ch_b), .wr_note(wr_note),
    .wr_oct(wr_oct_b), .wr_gate(wr_gate), .wr_err(wr_err_b),
    .tone_out(tone_b), .edge_tick(edge_b), .pending(pend_b)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit which;
    int ch;
    int note;
    int oct;
    bit gate;
    bit exp_err;
  } vec_t;

  vec_t vecs[11];

  task automatic checkOutput(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle write; returns #1 after the edge that samples it
  task automatic applyStimulus(input bit which, input int ch, input int note,
                               input int oct, input bit gate);
    wr_note = 4'(note);
    wr_gate = gate;
    if (which) begin
      wr_ch_b = 2'(ch);
      wr_oct_b = 4'(oct);
      wr_en_b = 1'b1;
    end else begin
      wr_ch_a = 2'(ch);
      wr_oct_a = 3'(oct);
      wr_en_a = 1'b1;
    end
    step();
    wr_en_a = 1'b0;
    wr_en_b = 1'b0;
  endtask

  // Cycles until tone_a[ch] changes; edge_tick must track every change
  task automatic waitToggle(input int ch, input int budget, output int n);
    logic prev;
    bit   tick_ok;
    prev = tone_a[ch];
    tick_ok = 1'b1;
    n = 0;
    do begin
      step();
      n++;
      if (edge_a[ch] != (tone_a[ch] != prev)) tick_ok = 1'b0;
    end while (tone_a[ch] == prev && n < budget);
    checkOutput($sformatf("tick_align_ch%0d", ch), int'(tick_ok), 1);
  endtask

  initial begin
    int  n;
    bit  quiet;

    vecs[0]  = '{0, 0, 9, 4, 0, 0};
    vecs[1]  = '{0, 1, 13, 0, 1, 1};
    vecs[2]  = '{0, 2, 12, 7, 0, 1};
    vecs[3]  = '{0, 3, 11, 7, 0, 0};
    vecs[4]  = '{0, 2, 15, 0, 0, 1};
    vecs[5]  = '{1, 3, 0, 0, 0, 1};
    vecs[6]  = '{1, 0, 0, 8, 0, 1};
    vecs[7]  = '{1, 2, 11, 7, 0, 0};
    vecs[8]  = '{1, 1, 5, 15, 0, 1};
    vecs[9]  = '{1, 1, 9, 8, 1, 1};
    vecs[10] = '{1, 0, 0, 0, 0, 0};

    repeat (3) step();
    rst = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (tone_a != 0 || edge_a != 0 || pend_a != 0 || wr_err_a) quiet = 1'b0;
    end
    checkOutput("idle_quiet", int'(quiet), 1);
    checkOutput("rst_tone_a", int'(tone_a), 0);
    checkOutput("rst_tick_a", int'(edge_a), 0);
    checkOutput("rst_pend_a", int'(pend_a), 0);
    checkOutput("rst_err_a", int'(wr_err_a), 0);
    checkOutput("rst_tone_b", int'(tone_b), 0);
    checkOutput("rst_pend_b", int'(pend_b), 0);
    checkOutput("rst_err_b", int'(wr_err_b), 0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].which, vecs[i].ch, vecs[i].note, vecs[i].oct, vecs[i].gate);
      if (vecs[i].which) begin
        checkOutput($sformatf("vec%0d_err", i), int'(wr_err_b), int'(vecs[i].exp_err));
        checkOutput($sformatf("vec%0d_pend", i), int'(pend_b), 0);
        step();
        checkOutput($sformatf("vec%0d_err_drop", i), int'(wr_err_b), 0);
      end else begin
        checkOutput($sformatf("vec%0d_err", i), int'(wr_err_a), int'(vecs[i].exp_err));
        checkOutput($sformatf("vec%0d_pend", i), int'(pend_a), 0);
        step();
        checkOutput($sformatf("vec%0d_err_drop", i), int'(wr_err_a), 0);
      end
    end

    // A7 on ch0: first rise and one full half-period
    applyStimulus(0, 0, 9, 7, 1);
    checkOutput("a7_wr_err", int'(wr_err_a), 0);
    checkOutput("a7_no_pend", int'(pend_a[0]), 0);
    waitToggle(0, THR_A7 + 50, n);
    checkOutput("a7_first_rise", n, THR_A7);
    checkOutput("a7_tone_high", int'(tone_a[0]), 1);
    waitToggle(0, THR_A7 + 50, n);
    checkOutput("a7_half", n, THR_A7);
    checkOutput("a7_tone_low", int'(tone_a[0]), 0);

    // Mid-period change to B7 is queued until the current boundary
    repeat (2000) step();
    applyStimulus(0, 0, 11, 7, 1);
    checkOutput("pend_set", int'(pend_a[0]), 1);
    waitToggle(0, THR_A7, n);
    checkOutput("old_half_kept", 2001 + n, THR_A7);
    checkOutput("pend_clear", int'(pend_a[0]), 0);
    waitToggle(0, THR_B7 + 50, n);
    checkOutput("b7_half", n, THR_B7);

    // Write landing exactly on a boundary edge
    repeat (THR_B7 - 1) step();
    applyStimulus(0, 0, 9, 7, 1);
    checkOutput("simul_toggle", int'(tone_a[0]), 1);
    checkOutput("simul_tick", int'(edge_a[0]), 1);
    checkOutput("simul_pend", int'(pend_a[0]), 1);
    waitToggle(0, THR_B7 + 50, n);
    checkOutput("simul_old_thr", n, THR_B7);
    checkOutput("simul_pend_clear", int'(pend_a[0]), 0);
    waitToggle(0, THR_A7 + 50, n);
    checkOutput("simul_new_thr", n, THR_A7);

    // ch1 gated on then off mid-period while ch0 keeps counting
    applyStimulus(0, 1, 11, 7, 1);
    waitToggle(1, THR_B7 + 50, n);
    checkOutput("ch1_rise", n, THR_B7);
    repeat (100) step();
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("ch1_gate_off", int'(tone_a[1]), 0);
    checkOutput("ch1_no_pend", int'(pend_a[1]), 0);
    waitToggle(0, THR_A7, n);
    checkOutput("ch0_undisturbed", 6429 + n, THR_A7);

    // Reset with a pending change in flight
    repeat (500) step();
    applyStimulus(0, 0, 4, 7, 1);
    checkOutput("pre_rst_pend", int'(pend_a[0]), 1);
    checkOutput("b_no_start", int'(tone_b), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checkOutput("rst_mid_tone", int'(tone_a), 0);
    checkOutput("rst_mid_tick", int'(edge_a), 0);
    checkOutput("rst_mid_pend", int'(pend_a), 0);
    quiet = 1'b1;
    for (int i = 0; i < THR_A7 + 100; i++) begin
      step();
      if (tone_a != 0 || edge_a != 0 || pend_a != 0) quiet = 1'b0;
    end
    checkOutput("post_rst_silent", int'(quiet), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
